// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared stage-register state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int c_def_data_w = 32;
    localparam int c_def_ctrl_w = 7;
    localparam int c_def_cnt_w  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// Module      : pipe_stage_buf
// Description : Two-entry skid-buffered pipeline stage register with flush,
//               bubble control masking and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int CTRL_W = c_def_ctrl_w,
    parameter int CNT_W  = c_def_cnt_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_t      r_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_stall;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_push      = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_stall     = w_out_valid & ~out_ready;

    // in_ready is recomputed from the next state so it stays a pure flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_head_ctrl <= '0;
            r_head_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_head_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_ctrl <= in_ctrl;
                        r_head_data <= in_data;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_ctrl <= in_ctrl;
                        r_head_data <= in_data;
                    end else if (w_push) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                        r_state     <= ST_FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head_ctrl <= r_skid_ctrl;
                        r_head_data <= r_skid_data;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall),
        .clear (1'b0),
        .count (stall_cnt)
    );

    // A bubble must never carry live write-back or memory-access bits.
    assign out_ctrl  = w_out_valid ? r_head_ctrl : '0;
    assign out_valid = w_out_valid;
    assign out_data  = r_head_data;
    assign in_ready  = r_in_ready;

endmodule : pipe_stage_buf

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Directed and scoreboard-checked bench for pipe_stage_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;

    localparam int DW = 32;
    localparam int CW = 7;
    localparam int NW = 16;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    logic          s_flush, s_in_valid, s_out_ready;
    logic [CW-1:0] s_in_ctrl;
    logic [DW-1:0] s_in_data;
    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [SW-1:0] s_stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(SW)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .stall_cnt(s_stall_cnt)
    );

    task automatic do_reset();
        flush = 0; in_valid = 0; out_ready = 0; in_ctrl = '0; in_data = '0;
        s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_ctrl = '0; s_in_data = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_ctrl, in_ready} !== {1'b0, 7'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b ctrl=%h ready=%b, expected valid=0 ctrl=00 ready=1",
                     out_valid, out_ctrl, in_ready);
        end
        checks++;
        if (out_data !== 32'h0 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_data_cnt: got data=%h cnt=%0d, expected data=0 cnt=0", out_data, stall_cnt);
        end
        checks++;
        if ({s_out_valid, s_in_ready, s_stall_cnt} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_sat_inst: got valid=%b ready=%b cnt=%0d, expected 0 1 0",
                     s_out_valid, s_in_ready, s_stall_cnt);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_data = DW'(i); in_ctrl = CW'(8'h10 + i);
            @(negedge clk);
            checks++;
            if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b1, CW'(8'h10 + i), DW'(i), 1'b1}) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b ctrl=%h data=%h ready=%b, expected 1 %h %h 1",
                         i, out_valid, out_ctrl, out_data, in_ready, CW'(8'h10 + i), DW'(i));
            end
        end
        in_valid = 0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b0, 7'h00, 32'd3}) begin
            errors++;
            $display("FAIL stream_drain: got valid=%b ctrl=%h data=%h, expected 0 00 00000003",
                     out_valid, out_ctrl, out_data);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        out_ready = 0;
        in_valid = 1; in_data = 32'hA; in_ctrl = 7'h0A;
        @(negedge clk);
        in_data = 32'hB; in_ctrl = 7'h0B;
        @(negedge clk);
        in_valid = 0;
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'hA}) begin
            errors++;
            $display("FAIL skid_full: got ready=%b valid=%b data=%h, expected 0 1 0000000a",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL skid_hold: got ready=%b cnt=%0d, expected ready=0 cnt=2", in_ready, stall_cnt);
        end
        out_ready = 1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b1, 7'h0B, 32'hB, 1'b1}) begin
            errors++;
            $display("FAIL skid_second: got valid=%b ctrl=%h data=%h ready=%b, expected 1 0b 0000000b 1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL skid_drain: got valid=%b cnt=%0d, expected valid=0 cnt=2", out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 0;
        in_valid = 1; in_data = 32'h1; in_ctrl = 7'h01;
        @(negedge clk);
        in_data = 32'h2; in_ctrl = 7'h02;
        @(negedge clk);
        flush = 1; in_valid = 1; in_ctrl = 7'h7F; in_data = 32'h7F;
        @(negedge clk);
        flush = 0; in_valid = 0;
        checks++;
        if ({out_valid, out_ctrl, in_ready} !== {1'b0, 7'h00, 1'b1}) begin
            errors++;
            $display("FAIL flush_full: got valid=%b ctrl=%h ready=%b, expected 0 00 1",
                     out_valid, out_ctrl, in_ready);
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL flush_keeps_cnt: got %0d expected 2", stall_cnt);
        end
        in_valid = 1; in_data = 32'h3; in_ctrl = 7'h03;
        @(negedge clk);
        flush = 1; in_ctrl = 7'h7F; in_data = 32'h7F;
        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 1;
        checks++;
        if ({out_valid, out_ctrl} !== {1'b0, 7'h00}) begin
            errors++;
            $display("FAIL flush_one: got valid=%b ctrl=%h, expected 0 00", out_valid, out_ctrl);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: got valid=%b data=%h, expected valid=0", out_valid, out_data);
        end
        in_valid = 1; in_data = 32'h33; in_ctrl = 7'h33;
        @(negedge clk);
        in_valid = 0;
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b1, 7'h33, 32'h33}) begin
            errors++;
            $display("FAIL flush_after_push: got valid=%b ctrl=%h data=%h, expected 1 33 00000033",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'h1; s_in_ctrl = 7'h01;
        @(negedge clk);
        s_in_valid = 0;
        checks++;
        if (s_out_valid !== 1'b1 || s_stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL sat_start: got valid=%b cnt=%0d, expected 1 0", s_out_valid, s_stall_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (s_stall_cnt !== 3'd3) begin
            errors++;
            $display("FAIL sat_mid: got %0d expected 3", s_stall_cnt);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (s_stall_cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_ten: got %0d expected 7", s_stall_cnt);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (s_stall_cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 7", s_stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 0;
        in_valid = 1; in_data = 32'h11; in_ctrl = 7'h11;
        @(negedge clk);
        in_data = 32'h22; in_ctrl = 7'h22;
        @(negedge clk);
        in_valid = 0;
        checks++;
        if (in_ready !== 1'b0 || stall_cnt === 16'd0) begin
            errors++;
            $display("FAIL arst_setup: got ready=%b cnt=%0d, expected ready=0 cnt>0", in_ready, stall_cnt);
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready, stall_cnt} !== {1'b0, 7'h00, 32'h0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL arst_async: got valid=%b ctrl=%h data=%h ready=%b cnt=%0d, expected 0 00 0 1 0",
                     out_valid, out_ctrl, out_data, in_ready, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1;
        out_ready = 1; in_valid = 1; in_data = 32'h55; in_ctrl = 7'h05;
        @(negedge clk);
        in_valid = 0;
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b1, 7'h05, 32'h55}) begin
            errors++;
            $display("FAIL arst_first_push: got valid=%b ctrl=%h data=%h, expected 1 05 00000055",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_random();
        logic [CW+DW-1:0] q[$];
        int stall_m;
        bit mv, mr, push, pop;
        do_reset();
        stall_m = 0;
        for (int c = 0; c < 10000; c++) begin
            mv = (q.size() != 0);
            mr = (q.size() < 2);
            checks++;
            if (out_valid !== mv || in_ready !== mr) begin
                errors++;
                $display("FAIL rand_flags cyc %0d: got valid=%b ready=%b, expected %b %b",
                         c, out_valid, in_ready, mv, mr);
            end
            checks++;
            if (mv) begin
                if ({out_ctrl, out_data} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d: got %h expected %h", c, {out_ctrl, out_data}, q[0]);
                end
            end else if (out_ctrl !== '0) begin
                errors++;
                $display("FAIL rand_bubble_ctrl cyc %0d: got %h expected 0", c, out_ctrl);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = $urandom;
            push = in_valid && mr;
            pop  = mv && out_ready;
            if (mv && !out_ready) stall_m++;
            @(negedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back({in_ctrl, in_data});
            end
        end
        flush = 0; in_valid = 0;
        checks++;
        if (stall_cnt !== NW'(stall_m)) begin
            errors++;
            $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, stall_m);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_stage_buf

`default_nettype wire

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the payload carried through the stage (result, store data, targets).
REQ-002 SHALL have parameter CTRL_W, default 7: width of the control field (WB and M bits); this field is zeroed whenever the stage holds a bubble.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous squash of all held entries.
REQ-008 in_valid  input  1  upstream presents an entry.
REQ-009 in_ready  output  1  stage can accept an entry; this output is registered.
REQ-010 in_ctrl  input  CTRL_W  upstream control field.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 out_valid  output  1  the head entry is valid.
REQ-013 out_ready  input  1  downstream accepts the head entry.
REQ-014 out_ctrl  output  CTRL_W  head control field; equals 0 when out_valid=0.
REQ-015 out_data  output  DATA_W  head payload; holds its last value when out_valid=0.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL be a two-entry skid buffer: a head register drives the outputs, and a skid register catches an entry accepted while the head is stalled.
REQ-018 SHALL have states EMPTY (0 entries), ONE (head only) and FULL (head and skid).
REQ-019 SHALL use these handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 EMPTY: push -> ONE, with head loaded from the inputs; visible on out_* the next cycle (1-cycle latency).
REQ-021 ONE: push & pop -> ONE, with head reloaded; push & !pop -> FULL, with skid loaded; pop & !push -> EMPTY.
REQ-022 FULL: pop -> ONE, with head loaded from skid; push is impossible because in_ready=0.
REQ-023 SHALL drive in_ready = (state != FULL), registered, so in_ready is never combinationally dependent on out_ready.
REQ-024 SHALL preserve order: entries leave in acceptance order, with no loss or duplication while flush=0.
REQ-025 flush SHALL have priority over push and pop in the same cycle: next state is EMPTY, out_valid=0 and out_ctrl=0 the next cycle, and the same-cycle input is discarded.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with out_valid & !out_ready, SHALL saturate at all-ones, and SHALL NOT wrap.
REQ-027 stall_cnt SHALL NOT be cleared by flush; only reset clears it.
REQ-028 When out_valid=0, out_ctrl SHALL be 0 regardless of register contents, so a bubble never writes back or accesses memory.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately, without a clock, force state EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0 and the skid register to 0.
REQ-030 Reset asserted mid-transfer SHALL drop all held entries; the first push after deassertion SHALL behave as from EMPTY.
REQ-031 No output SHALL be X after reset.

Structure
REQ-032 The state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default widths SHALL live in a shared package pipe_pkg, reused by the other stage registers.
REQ-033 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; inputs inc and clear) so the other stages can reuse it.
REQ-034 The block SHALL contain no other sub-modules.

Verification
REQ-035 Streaming: the bench SHALL push data 1,2,3 on consecutive cycles with out_ready=1 -> out_data 1,2,3 with out_valid=1 one cycle after each push; stall_cnt stays 0.
REQ-036 Stall/skid: the bench SHALL push 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0; then raise out_ready -> 0xA then 0xB appear in order; stall_cnt=2.
REQ-037 Flush: the bench SHALL reach FULL, then assert flush together with in_valid=1 and in_ctrl=7'h7F -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the 0x7F entry never appears.
REQ-038 Saturation: the bench SHALL use CNT_W=3 and hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=7 and stays 7.
REQ-039 Async reset: the bench SHALL drop rst_n between clock edges while FULL -> outputs reach their reset values before the next edge; after release, a push of 0x55 is seen after 1 cycle.
REQ-040 Random: the bench SHALL run 10k cycles of random in_valid, out_ready and flush against a scoreboard queue -> zero order or data mismatches, and out_ctrl=0 on every cycle with out_valid=0.
